// File: rtl/tally_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tally_pkg
// Description : Shared state encoding, mux select codes and class mask indices.
// Revision    : 1.0 - initial release
// ============================================================================
package tally_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_S0 = 2'b00;
  localparam logic [1:0] c_S1 = 2'b01;
  localparam logic [1:0] c_S2 = 2'b10;
  localparam logic [1:0] c_S3 = 2'b11;

  localparam int c_MASK_W    = 4;
  localparam int c_MASK_ZERO = 0;  // count = 0
  localparam int c_MASK_LOW  = 1;  // count in {1,2,4}
  localparam int c_MASK_MID  = 2;  // count in {3,5,6}
  localparam int c_MASK_ALL  = 3;  // count = 7

endpackage
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
// Module      : encoder
// Description : 7-bit population count.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder (
  input  logic [6:0] x,
  output logic [2:0] y
);

  always_comb begin
    y = 3'd0;
    for (int i = 0; i < 7; i++) begin
      y = y + {2'b00, x[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
// Module      : mux
// Description : 4-way popcount class selector; z flags membership of class s.
// Revision    : 1.0 - initial release
// ============================================================================
module mux (
  input  logic [2:0] y,
  input  logic [1:0] s,
  output logic       z
);

  always_comb begin
    z = 1'b0;
    case (s)
      2'b00:   z = (y == 3'd0);
      2'b01:   z = (y == 3'd1) || (y == 3'd2) || (y == 3'd4);
      2'b10:   z = (y == 3'd3) || (y == 3'd5) || (y == 3'd6);
      default: z = (y == 3'd7);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tally_sweep_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tally_sweep_fsm
// Description : IDLE/SWEEP/DONE sequencer, select counter and class mask capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tally_sweep_fsm
  import tally_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_in_valid,
  input  logic                i_out_ready,
  input  logic                i_z,
  output logic                o_in_ready,
  output logic                o_out_valid,
  output logic                o_busy,
  output logic                o_load,
  output logic                o_done,
  output logic [1:0]          o_sel,
  output logic [c_MASK_W-1:0] o_mask
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_sel;
  logic [c_MASK_W-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= c_S0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_load) begin
        r_sel  <= c_S0;
        r_mask <= '0;
      end else if (r_state == ST_SWEEP) begin
        // Select wraps back to S0 on the same edge that enters DONE.
        r_mask[r_sel] <= i_z;
        r_sel         <= r_sel + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_load      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          o_load      = 1'b1;
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        o_busy = 1'b1;
        if (r_sel == c_S3) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          o_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_sel  = r_sel;
  assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/tally_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tally_sweep_ctrl
// Description : Accepts a vote word, sweeps the class mux, returns count + mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tally_sweep_ctrl
  import tally_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_count,
  output logic [c_MASK_W-1:0] out_mask,
  output logic [1:0]          sel,
  output logic                busy,
  output logic [CNT_W-1:0]    done_cnt
);

  logic [6:0]       r_x_q;
  logic [CNT_W-1:0] r_done_cnt;
  logic [2:0]       w_y;
  logic             w_z;
  logic             w_load;
  logic             w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_q      <= 7'd0;
      r_done_cnt <= '0;
    end else begin
      if (w_load) begin
        r_x_q <= in_data;
      end
      if (w_done) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
    end
  end

  encoder u_encoder (
    .x (r_x_q),
    .y (w_y)
  );

  mux u_mux (
    .y (w_y),
    .s (sel),
    .z (w_z)
  );

  tally_sweep_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .i_z         (w_z),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_load      (w_load),
    .o_done      (w_done),
    .o_sel       (sel),
    .o_mask      (out_mask)
  );

  assign out_count = w_y;
  assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tally_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tally_sweep_ctrl
// Description : Directed bench with a cycle-level reference model for tally_sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tally_sweep_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_data = 7'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_count;
  logic [3:0]       out_mask;
  logic [1:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  tally_sweep_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_mask  (out_mask),
    .sel       (sel),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int popc(input logic [6:0] w);
    int c = 0;
    for (int i = 0; i < 7; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic int cls(input int c);
    if (c == 0) return 1;
    if (c == 7) return 8;
    if (c == 1 || c == 2 || c == 4) return 2;
    return 4;
  endfunction

  // Reference model: a job is either absent or some number of edges old.
  logic       m_init = 1'b0;
  logic       m_on   = 1'b0;
  int         m_age  = 0;
  logic [6:0] m_word = 7'd0;
  int         m_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_on   <= 1'b0;
      m_age  <= 0;
      m_word <= 7'd0;
      m_done <= 0;
    end else if (!m_on) begin
      if (in_valid) begin
        m_on   <= 1'b1;
        m_age  <= 0;
        m_word <= in_data;
      end
    end else if (m_age >= 4) begin
      if (out_ready) begin
        m_on   <= 1'b0;
        m_done <= (m_done + 1) % (1 << CNT_W);
      end
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",  int'(in_ready),  int'(!m_on));
      chk("out_valid", int'(out_valid), int'(m_on && m_age >= 4));
      chk("busy",      int'(busy),      int'(m_on));
      chk("sel",       int'(sel),       (m_on && m_age < 4) ? m_age : 0);
      chk("done_cnt",  int'(done_cnt),  m_done);
      if (m_on && m_age >= 4) begin
        chk("out_count", int'(out_count), popc(m_word));
        chk("out_mask",  int'(out_mask),  cls(popc(m_word)));
        chk("mask_onehot", $countones(out_mask), 1);
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    while (!in_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", int'(in_ready), 1);
  endtask

  // Returns number of negedges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_timeout", int'(out_valid), 1);
  endtask

  task automatic run_word(input logic [6:0] d, input int ec, input int em, input int edone);
    int lat;
    wait_idle();
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("latency", lat, 4);
    chk("class_count", int'(out_count), ec);
    chk("class_mask",  int'(out_mask),  em);
    @(negedge clk);
    chk("done_after_hs", int'(done_cnt), edone);
  endtask

  initial begin : stim
    int lat;
    int last_acc;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_mask",  int'(out_mask),  0);
    chk("rst_done_cnt",  int'(done_cnt),  0);
    rst = 1'b0;
    @(negedge clk);

    // Class boundaries; done_cnt also wraps 1,2,3,0 at CNT_W=2
    run_word(7'b0000000, 0, 4'b0001, 1);
    run_word(7'b0100000, 1, 4'b0010, 2);
    run_word(7'b0001011, 3, 4'b0100, 3);
    run_word(7'b1111111, 7, 4'b1000, 0);

    // Backpressure
    wait_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 7'b0110011;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid",    int'(out_valid), 1);
      chk("bp_count",    int'(out_count), 4);
      chk("bp_mask",     int'(out_mask),  4'b0010);
      chk("bp_in_ready", int'(in_ready),  0);
      chk("bp_done",     int'(done_cnt),  0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_inc", int'(done_cnt), 1);

    // Busy drop: second word offered during SWEEP must wait for IDLE
    wait_idle();
    in_valid = 1'b1;
    in_data  = 7'b0000001;
    @(negedge clk);
    in_data = 7'b1111111;
    wait_valid(lat);
    chk("drop_count", int'(out_count), 1);
    chk("drop_mask",  int'(out_mask),  4'b0010);
    @(negedge clk);
    chk("drop_idle", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_busy", int'(busy), 1);
    wait_valid(lat);
    chk("drop2_count", int'(out_count), 7);
    chk("drop2_mask",  int'(out_mask),  4'b1000);
    @(negedge clk);

    // Reset during sweep, asserted for edge A+2
    wait_idle();
    in_valid = 1'b1;
    in_data  = 7'b1010101;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_in_ready",  int'(in_ready),  1);
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_out_mask",  int'(out_mask),  0);
    chk("mid_done_cnt",  int'(done_cnt),  0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mid_no_result", int'(out_valid), 0);
    end

    // Back-to-back random words
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 0;
    for (int k = 0; k < 10; k++) begin
      wait_idle();
      in_data = 7'($urandom_range(0, 127));
      if (k > 0) chk("b2b_interval", cyc - last_acc, 6);
      last_acc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tally_sweep_ctrl.md
# tally_sweep_ctrl

Sequencer for the 7-bit popcount `encoder` and the 4-way class `mux`. It accepts one 7-bit vote word through a valid/ready handshake and holds it in a register feeding `encoder`. It then sweeps the `mux` select through S0..S3, one per cycle, and collects each `z` into a 4-bit class mask. The count and mask are presented through a valid/ready output handshake, and completed words are counted in a wrapping statistics counter.

## Interface
- `CNT_W`, default 8: width of the completed-word counter.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  block can accept a word; high only in IDLE.
- `in_data`  input  7  vote word; one bit per voter.
- `out_valid`  output  1  `out_count` and `out_mask` are valid; high only in DONE.
- `out_ready`  input  1  consumer accepts the result.
- `out_count`  output  3  popcount of the accepted word (`encoder` `y`).
- `out_mask`  output  4  `out_mask[k]` is the `mux` `z` captured with `s = k`.
- `sel`  output  2  current `mux` select; exported for debug.
- `busy`  output  1  high in SWEEP or DONE.
- `done_cnt`  output  `CNT_W`  completed output handshakes, modulo 2^`CNT_W`.

## Operation
- FSM states are IDLE, SWEEP and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `in_data` into `x_q`, clear the mask, set `sel`=0 and go to SWEEP.
- SWEEP:
  - `encoder` sees `x_q` and `mux` sees (`y`, `sel`).
  - Each edge stores `z` into `mask[sel]` and increments `sel`.
  - The edge that captures `sel`=3 moves the FSM to DONE; `sel` wraps to 0.
- DONE:
  - `out_valid`=1; `out_count`=`y` and `out_mask`=mask.
  - Outputs and `x_q` stay stable until `out_valid && out_ready`.
  - On that handshake: go to IDLE and increment `done_cnt`.
- Mask semantics (a self-check invariant): exactly one bit of `out_mask` is set.
  - bit0: count = 0.
  - bit1: count ∈ {1,2,4}.
  - bit2: count ∈ {3,5,6}.
  - bit3: count = 7.
- `in_valid` outside IDLE is ignored; the word is neither consumed nor buffered.
- `done_cnt` wraps from 2^`CNT_W`−1 to 0 without saturating.
- Reset values:
  - State IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `sel`=0, `x_q`=0, mask=0, `out_count`=0, `out_mask`=0, `done_cnt`=0.
- Reset mid-operation (SWEEP or DONE):
  - The word in flight is discarded and no output handshake occurs.
  - `done_cnt` clears.
  - `rst` overrides a simultaneous input or output handshake.

## Timing
- Accept edge A. Mask bits are captured at edges A+1..A+4.
- `out_valid` is high in the cycle after edge A+4, so latency is 4 cycles from the accept edge.
- With `out_ready` held high:
  - Output handshake at A+5.
  - `in_ready` high after A+5; next accept at A+6.
  - Throughput is one word per 6 cycles.
- No combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`. Both ready/valid outputs are decoded from the FSM register only.
- `sel` is registered. `encoder`/`mux` form a combinational path from `x_q` and `sel` to the mask register; it must close in one cycle.

## Structure
- Package `tally_pkg` holds:
  - State encoding: IDLE=2'd0, SWEEP=2'd1, DONE=2'd2.
  - Select constants S0..S3 = 2'b00..2'b11, matching `mux`.
  - Mask bit indices.
- Instantiate the existing `encoder` and `mux` unchanged; do not re-derive their logic.
- One natural sub-module, `tally_sweep_fsm`: state register, `sel` counter and mask capture. The top holds `x_q`, `done_cnt` and the instances.

## Test plan
- Class boundaries, each with `out_ready`=1:
  - `in_data`=7'b0000000 → `out_count`=0, `out_mask`=4'b0001.
  - 7'b0100000 → count 1, mask 4'b0010.
  - 7'b0001011 → count 3, mask 4'b0100.
  - 7'b1111111 → count 7, mask 4'b1000.
  - Each case: `out_valid` rises 4 cycles after the accept edge.
- Backpressure: 7'b0110011 accepted, `out_ready` low for 3 cycles.
  - `out_valid` holds with count 4, mask 4'b0010, both stable.
  - `in_ready`=0 throughout; `done_cnt` increments only on the cycle `out_ready` rises.
- Busy drop: second word 7'b1111111 offered during SWEEP.
  - Not accepted; the result is the first word's.
  - 7'b1111111 is accepted only once IDLE is re-entered.
- Reset mid-sweep: `rst` at A+2.
  - Next cycle: state IDLE, `out_valid`=0, `out_mask`=0, `done_cnt`=0.
  - No result is ever presented for the discarded word.
- Counter wrap with `CNT_W`=2: four completed words → `done_cnt` sequence 1,2,3,0.
- Back-to-back: continuous `in_valid` and `out_ready` over 10 random words.
  - One accept per 6 cycles.
  - Every mask is one-hot and matches a reference popcount class.
